i2c_txn_arbiter: RTL and testbench
==================================

// Module: i2c_txn_arbiter
// PURPOSE
//  Shares one i2c_master between NUM_REQ client blocks.
//  Each client posts a single-byte transaction: 7-bit address, rw, and write data.
//  A round-robin scheduler picks one client, latches its request and drives the master's start/addr/rw/data_send.
//  It then waits for i2c_done (or a timeout) and returns read data to the granted client only.
//  Sits between system-side clients and the i2c_master instance.
// PARAMETERS
//  NUM_REQ         4       number of requesters (>=1)
//  TIMEOUT_CYCLES  50000   clk cycles in WAIT before the transaction is abandoned (>=2)
//  IDX_W           log2(NUM_REQ-1), min 1   width of grant index
// PORTS
//  clk           in   1          system clock; all logic on posedge
//  arstn         in   1          reset; synchronous, active-low
//  req_valid     in   NUM_REQ    per-client request pending; level, held until req_ack
//  req_addr      in   NUM_REQ*7  client i address at [i*7 +: 7]
//  req_rw        in   NUM_REQ    1 = read, 0 = write
//  req_wdata     in   NUM_REQ*8  client i write byte at [i*8 +: 8]
//  req_ack       out  NUM_REQ    one-cycle one-hot pulse: request accepted
//  rsp_valid     out  NUM_REQ    one-cycle one-hot pulse: transaction finished
//  rsp_rdata     out  8          read byte; valid with rsp_valid
//  rsp_timeout   out  1          transaction timed out; valid with rsp_valid
//  busy          out  1          high in any state other than IDLE
//  m_start       out  1          to i2c_master.i2c_start; one-cycle pulse
//  m_addr        out  7          to i2c_master.addr
//  m_rw          out  1          to i2c_master.rw
//  m_data_send   out  8          to i2c_master.data_send
//  m_done        in   1          from i2c_master.i2c_done; one-cycle pulse
//  m_data_recv   in   8          from i2c_master.data_recv
// BEHAVIOUR
//  Reset (arstn=0 at posedge):
//   - state = IDLE; all outputs = 0; timeout counter = 0.
//   - last_grant = NUM_REQ-1, so client 0 has first priority.
//   - Reset mid-transaction abandons it silently: no rsp_valid is issued.
//  FSM states: IDLE, ISSUE, WAIT, RESP.
//   IDLE:
//    - If any req_valid: pick g = first set bit scanning from last_grant+1 with wrap-around.
//    - Latch addr/rw/wdata of g into m_addr/m_rw/m_data_send and g into cur_idx.
//    - req_ack[g]=1 for the next cycle, then go to ISSUE.
//    - No req_valid: stay in IDLE.
//   ISSUE:
//    - m_start=1 for exactly this cycle; clear timeout counter; go to WAIT.
//   WAIT:
//    - Count cycles.
//    - m_done=1: capture m_data_recv into rsp_rdata, rsp_timeout=0, go to RESP.
//    - Counter reaches TIMEOUT_CYCLES-1 without m_done: rsp_rdata=0, rsp_timeout=1, go to RESP.
//    - m_done and the terminal count in the same cycle: m_done wins.
//   RESP:
//    - rsp_valid[cur_idx]=1 for exactly this cycle.
//    - last_grant = cur_idx; go to IDLE.
//  Stability and gating:
//   - m_addr/m_rw/m_data_send hold from ISSUE through RESP.
//   - rsp_rdata/rsp_timeout hold until the next RESP.
//  Latency:
//   - req_valid sampled in IDLE -> req_ack next cycle.
//   - m_start one cycle after req_ack.
//   - rsp_valid one cycle after m_done.
//   - Minimum IDLE-to-IDLE is 4 cycles plus bus time.
//  Client rules:
//   - Client must drop req_valid in the cycle after req_ack; a still-high req_valid in IDLE is a new request.
//   - req_valid dropped before it is sampled counts as withdrawn: no ack.
//   - req_* changes after ack are ignored.
//  Fairness: a client that has just been served has lowest priority in the next arbitration.
//  m_done outside WAIT is ignored.
//  NUM_REQ=1: arbiter degenerates to always granting index 0.
// STRUCTURE
//  - Shared package i2c_pkg: FSM state localparams (2-bit), the log2 function, address width 7 and data width 8.
//  - One sub-module, i2c_rr_arbiter:
//    - Combinational.
//    - Inputs: req vector and last_grant.
//    - Outputs: one-hot grant, grant index, any_req.
//  - FSM, latches and timeout counter live in the top level.
// TESTING
//  - Reset:
//    - Hold arstn=0 for 3 cycles with req_valid=4'b1111.
//    - Expect all outputs 0 and no ack.
//    - After release, first req_ack=4'b0001.
//  - Single write:
//    - Client 2 posts addr=7'h50, rw=0, wdata=8'hA5.
//    - Expect req_ack=4'b0100.
//    - Expect m_start pulse with m_addr=7'h50, m_data_send=8'hA5.
//    - Model asserts m_done after 100 cycles -> rsp_valid=4'b0100, rsp_timeout=0.
//  - Single read:
//    - Client 1 posts rw=1; model returns m_data_recv=8'h3C with m_done.
//    - Expect rsp_valid=4'b0010, rsp_rdata=8'h3C.
//  - Round-robin: all 4 clients held valid continuously -> grant order 0,1,2,3,0; no client granted twice in a row.
//  - Timeout:
//    - TIMEOUT_CYCLES=20; model never asserts m_done.
//    - Expect rsp_valid 20 cycles after the WAIT entry, rsp_timeout=1, rsp_rdata=0, then IDLE.
//  - Collision: m_done on the terminal timeout cycle -> rsp_timeout=0, data captured.
//  - Mid-transaction reset in WAIT -> no rsp_valid; next grant goes to client 0.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared types and helpers for the I2C transaction arbiter: FSM encoding,
// bus field widths and a bit-width helper for sizing parameters.
package i2c_pkg;

    localparam int ADDR_W = 7;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    // Bits needed to hold the value n, never less than 1.
    function automatic int log2(input int n);
        int w;
        w = 1;
        while ((1 << w) <= n) w++;
        return w;
    endfunction

endpackage

// File: rtl/i2c_rr_arbiter.sv
// Combinational round-robin picker: first pending request after last_grant_i,
// wrapping around, so the most recently served client is considered last.
module i2c_rr_arbiter
    import i2c_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = log2(NUM_REQ - 1)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   last_grant_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   grant_idx_o,
    output logic               any_req_o
);

    always_comb begin
        logic found;
        int   idx;
        grant_o     = '0;
        grant_idx_o = '0;
        any_req_o   = |req_i;
        found       = 1'b0;
        idx         = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last_grant_i) + k) % NUM_REQ;
            if (req_i[idx] && !found) begin
                found        = 1'b1;
                grant_o[idx] = 1'b1;
                grant_idx_o  = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/i2c_txn_arbiter.sv
// Shares one i2c_master among NUM_REQ clients: round-robin grant, one
// single-byte transaction at a time, with a WAIT-state timeout.
module i2c_txn_arbiter
    import i2c_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int IDX_W          = log2(NUM_REQ - 1)
) (
    input  logic                      clk,
    input  logic                      arstn,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ-1:0]        req_rw,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ack,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_timeout,
    output logic                      busy,
    output logic                      m_start,
    output logic [ADDR_W-1:0]         m_addr,
    output logic                      m_rw,
    output logic [DATA_W-1:0]         m_data_send,
    input  logic                      m_done,
    input  logic [DATA_W-1:0]         m_data_recv
);

    localparam int CNT_W = log2(TIMEOUT_CYCLES - 1);

    state_t               state_q;
    logic [IDX_W-1:0]     last_grant_q;
    logic [IDX_W-1:0]     cur_idx_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [NUM_REQ-1:0]   req_ack_q;
    logic [NUM_REQ-1:0]   rsp_valid_q;
    logic [DATA_W-1:0]    rsp_rdata_q;
    logic                 rsp_timeout_q;
    logic                 m_start_q;
    logic [ADDR_W-1:0]    m_addr_q;
    logic                 m_rw_q;
    logic [DATA_W-1:0]    m_data_send_q;

    logic [NUM_REQ-1:0]   grant_oh;
    logic [IDX_W-1:0]     grant_idx;
    logic                 any_req;

    i2c_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req_i        (req_valid),
        .last_grant_i (last_grant_q),
        .grant_o      (grant_oh),
        .grant_idx_o  (grant_idx),
        .any_req_o    (any_req)
    );

    always_ff @(posedge clk) begin
        if (!arstn) begin
            state_q       <= S_IDLE;
            last_grant_q  <= IDX_W'(NUM_REQ - 1);
            cur_idx_q     <= '0;
            cnt_q         <= '0;
            req_ack_q     <= '0;
            rsp_valid_q   <= '0;
            rsp_rdata_q   <= '0;
            rsp_timeout_q <= 1'b0;
            m_start_q     <= 1'b0;
            m_addr_q      <= '0;
            m_rw_q        <= 1'b0;
            m_data_send_q <= '0;
        end else begin
            req_ack_q   <= '0;
            rsp_valid_q <= '0;
            m_start_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (any_req) begin
                        m_addr_q      <= req_addr[grant_idx*ADDR_W +: ADDR_W];
                        m_rw_q        <= req_rw[grant_idx];
                        m_data_send_q <= req_wdata[grant_idx*DATA_W +: DATA_W];
                        cur_idx_q     <= grant_idx;
                        req_ack_q     <= grant_oh;
                        state_q       <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    m_start_q <= 1'b1;
                    cnt_q     <= '0;
                    state_q   <= S_WAIT;
                end
                S_WAIT: begin
                    // m_done takes priority over a coincident terminal count
                    if (m_done) begin
                        rsp_rdata_q   <= m_data_recv;
                        rsp_timeout_q <= 1'b0;
                        rsp_valid_q   <= NUM_REQ'(1) << cur_idx_q;
                        state_q       <= S_RESP;
                    end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        rsp_rdata_q   <= '0;
                        rsp_timeout_q <= 1'b1;
                        rsp_valid_q   <= NUM_REQ'(1) << cur_idx_q;
                        state_q       <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_RESP: begin
                    last_grant_q <= cur_idx_q;
                    state_q      <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req_ack     = req_ack_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_timeout = rsp_timeout_q;
    assign busy        = (state_q != S_IDLE);
    assign m_start     = m_start_q;
    assign m_addr      = m_addr_q;
    assign m_rw        = m_rw_q;
    assign m_data_send = m_data_send_q;

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Directed bench: dut_a (long timeout) covers normal traffic and round-robin,
// dut_b (TIMEOUT_CYCLES=20) covers timeout, collision and mid-transaction reset.
module tb_i2c_txn_arbiter;

    logic        clk = 1'b0;
    logic        arstn;
    logic [3:0]  req_valid;
    logic [27:0] req_addr;
    logic [3:0]  req_rw;
    logic [31:0] req_wdata;
    logic        m_done;
    logic [7:0]  m_data_recv;

    logic [3:0] req_ack_a, rsp_valid_a, req_ack_b, rsp_valid_b;
    logic [7:0] rsp_rdata_a, m_data_send_a, rsp_rdata_b, m_data_send_b;
    logic [6:0] m_addr_a, m_addr_b;
    logic       rsp_timeout_a, busy_a, m_start_a, m_rw_a;
    logic       rsp_timeout_b, busy_b, m_start_b, m_rw_b;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    i2c_txn_arbiter #(.NUM_REQ(4), .TIMEOUT_CYCLES(200)) dut_a (
        .clk(clk), .arstn(arstn), .req_valid(req_valid), .req_addr(req_addr),
        .req_rw(req_rw), .req_wdata(req_wdata), .req_ack(req_ack_a),
        .rsp_valid(rsp_valid_a), .rsp_rdata(rsp_rdata_a), .rsp_timeout(rsp_timeout_a),
        .busy(busy_a), .m_start(m_start_a), .m_addr(m_addr_a), .m_rw(m_rw_a),
        .m_data_send(m_data_send_a), .m_done(m_done), .m_data_recv(m_data_recv)
    );

    i2c_txn_arbiter #(.NUM_REQ(4), .TIMEOUT_CYCLES(20)) dut_b (
        .clk(clk), .arstn(arstn), .req_valid(req_valid), .req_addr(req_addr),
        .req_rw(req_rw), .req_wdata(req_wdata), .req_ack(req_ack_b),
        .rsp_valid(rsp_valid_b), .rsp_rdata(rsp_rdata_b), .rsp_timeout(rsp_timeout_b),
        .busy(busy_b), .m_start(m_start_b), .m_addr(m_addr_b), .m_rw(m_rw_b),
        .m_data_send(m_data_send_b), .m_done(m_done), .m_data_recv(m_data_recv)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        arstn = 1'b0;
        tick();
        arstn = 1'b1;
    endtask

    // Bounded wait for an ack on dut_a; returns 0 if none arrives.
    task automatic wait_ack_a(output logic [3:0] ack);
        ack = '0;
        for (int n = 0; n < 20; n++) begin
            tick();
            if (req_ack_a != '0) begin
                ack = req_ack_a;
                break;
            end
        end
    endtask

    initial begin
        logic [3:0] ack, prev;
        logic [3:0] exp_rr [5];
        logic       early;
        exp_rr = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        arstn       = 1'b0;
        req_valid   = 4'b1111;
        req_addr    = '0;
        req_rw      = '0;
        req_wdata   = '0;
        m_done      = 1'b0;
        m_data_recv = '0;

        // Reset held 3 cycles with all clients requesting
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("reset_outputs", {req_ack_a, rsp_valid_a, rsp_rdata_a, rsp_timeout_a, busy_a,
                                  m_start_a, m_addr_a, m_rw_a, m_data_send_a}, 32'h0);
        end
        arstn = 1'b1;
        tick();
        chk("first_ack_client0", req_ack_a, 4'b0001);
        req_valid = 4'b0000;
        tick();
        chk("first_start", m_start_a, 1'b1);
        m_done = 1'b1;
        tick();
        m_done = 1'b0;
        chk("first_rsp", rsp_valid_a, 4'b0001);
        tick();

        // Single write from client 2, bus completes 100 cycles after start
        req_addr[2*7 +: 7]  = 7'h50;
        req_rw[2]           = 1'b0;
        req_wdata[2*8 +: 8] = 8'hA5;
        req_valid           = 4'b0100;
        tick();
        chk("wr_ack", req_ack_a, 4'b0100);
        chk("wr_busy", busy_a, 1'b1);
        req_valid = 4'b0000;
        tick();
        chk("wr_start_fields", {m_start_a, m_rw_a, m_addr_a, m_data_send_a}, {1'b1, 1'b0, 7'h50, 8'hA5});
        early = 1'b0;
        for (int i = 0; i < 99; i++) begin
            tick();
            if (rsp_valid_a != '0 || m_start_a) early = 1'b1;
        end
        chk("wr_quiet_wait", early, 1'b0);
        chk("wr_fields_held", {m_addr_a, m_data_send_a}, {7'h50, 8'hA5});
        m_done = 1'b1;
        tick();
        m_done = 1'b0;
        chk("wr_rsp", {rsp_valid_a, rsp_timeout_a}, {4'b0100, 1'b0});
        tick();
        chk("wr_back_idle", {busy_a, rsp_valid_a}, 5'h0);

        // Single read from client 1
        req_addr[1*7 +: 7] = 7'h21;
        req_rw[1]          = 1'b1;
        req_valid          = 4'b0010;
        tick();
        chk("rd_ack", req_ack_a, 4'b0010);
        req_valid = 4'b0000;
        tick();
        chk("rd_start_fields", {m_start_a, m_rw_a, m_addr_a}, {1'b1, 1'b1, 7'h21});
        tick();
        tick();
        m_done      = 1'b1;
        m_data_recv = 8'h3C;
        tick();
        m_done      = 1'b0;
        m_data_recv = 8'h00;
        chk("rd_rsp", {rsp_valid_a, rsp_rdata_a, rsp_timeout_a}, {4'b0010, 8'h3C, 1'b0});
        tick();
        tick();
        chk("rd_data_held", rsp_rdata_a, 8'h3C);

        // Round-robin with all four clients held valid
        do_reset();
        req_valid = 4'b1111;
        prev = '0;
        for (int i = 0; i < 5; i++) begin
            wait_ack_a(ack);
            chk($sformatf("rr_grant%0d", i), ack, exp_rr[i]);
            if (i > 0) chk($sformatf("rr_no_repeat%0d", i), ack != prev, 1'b1);
            prev = ack;
            tick();
            m_done = 1'b1;
            tick();
            m_done = 1'b0;
        end
        req_valid = 4'b0000;
        tick();

        // Timeout on dut_b: no m_done, response exactly 20 cycles after WAIT entry
        do_reset();
        m_data_recv        = 8'hFF;
        req_addr[3*7 +: 7] = 7'h11;
        req_rw[3]          = 1'b1;
        req_valid          = 4'b1000;
        tick();
        chk("to_ack", req_ack_b, 4'b1000);
        req_valid = 4'b0000;
        tick();
        chk("to_start", m_start_b, 1'b1);
        early = 1'b0;
        for (int i = 0; i < 19; i++) begin
            tick();
            if (rsp_valid_b != '0) early = 1'b1;
        end
        chk("to_not_early", early, 1'b0);
        tick();
        chk("to_rsp", {rsp_valid_b, rsp_timeout_b, rsp_rdata_b}, {4'b1000, 1'b1, 8'h00});
        tick();
        chk("to_back_idle", {busy_b, rsp_valid_b}, 5'h0);
        chk("to_flag_held", rsp_timeout_b, 1'b1);

        // Collision: m_done on the terminal-count cycle
        do_reset();
        m_data_recv        = 8'h00;
        req_addr[0*7 +: 7] = 7'h22;
        req_rw[0]          = 1'b1;
        req_valid          = 4'b0001;
        tick();
        chk("col_ack", req_ack_b, 4'b0001);
        req_valid = 4'b0000;
        tick();
        early = 1'b0;
        for (int i = 0; i < 19; i++) begin
            tick();
            if (rsp_valid_b != '0) early = 1'b1;
        end
        chk("col_not_early", early, 1'b0);
        m_done      = 1'b1;
        m_data_recv = 8'h5A;
        tick();
        m_done      = 1'b0;
        m_data_recv = 8'h00;
        chk("col_rsp", {rsp_valid_b, rsp_timeout_b, rsp_rdata_b}, {4'b0001, 1'b0, 8'h5A});
        tick();

        // Reset in WAIT: transaction dropped silently, priority back to client 0
        req_valid = 4'b0100;
        tick();
        chk("mr_ack", req_ack_b, 4'b0100);
        req_valid = 4'b0000;
        for (int i = 0; i < 6; i++) tick();
        do_reset();
        m_done = 1'b1;
        tick();
        m_done = 1'b0;
        early = 1'b0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (rsp_valid_b != '0 || rsp_valid_a != '0 || busy_b) early = 1'b1;
        end
        chk("mr_silent", early, 1'b0);
        req_valid = 4'b1111;
        tick();
        chk("mr_next_grant", {req_ack_a, req_ack_b}, {4'b0001, 4'b0001});
        req_valid = 4'b0000;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
